pipe_hazard_unit: RTL
=====================

# pipe_hazard_unit

Parametrised hazard, forwarding and flush controller for the next-generation pipelined RV32 core. It keeps its own shadow of every in-flight instruction after ID: valid, rd, RegWrite, MemRead. From that shadow it generates load-use stalls, branch/jump flushes, memory-busy freezes and per-operand forwarding selects for the EX stage. It sits beside the ID/EX, EX/MEM and MEM/WB registers, which it controls but does not hold.

## Interface
Parameters:
- `PIPE_DEPTH`, 3: number of pipeline registers after ID (1 = ID/EX … PIPE_DEPTH = last before RF write). Legal range ≥2.
- `LOAD_READY`, 3: shadow index at which load data first becomes forwardable. Legal range 2..PIPE_DEPTH.
- `REG_AW`, 5: register address width.
- `CNT_W`, 16: performance counter width.

Ports (FW = clog2(PIPE_DEPTH+2)):
- `clk` in 1: clock. One clock domain.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in REG_AW: ID source registers.
- `id_use_rs1`, `id_use_rs2` in 1: source is actually read.
- `id_rd` in REG_AW: ID destination.
- `id_regwrite`, `id_memread` in 1: ID writes RF / is a load.
- `ex_redirect` in 1: EX resolved a taken branch, jal or jalr this cycle.
- `mem_busy` in 1: data memory not ready; whole pipe must hold.
- `stall` out 1: hold PC and IF/ID.
- `bubble` out 1: load a NOP (valid=0) into ID/EX.
- `flush_ifid` out 1: invalidate IF/ID.
- `freeze` out 1: hold every pipeline register.
- `fwd_a_sel`, `fwd_b_sel` out FW: EX operand source. 0 = value latched in ID/EX. k (2..PIPE_DEPTH+1) = result of shadow entry k.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters.

## Operation
- Shadow entries 1..PIPE_DEPTH+1 each hold {valid, rd, regwrite, memread}. Entry 1 additionally holds rs1, rs2, use_rs1 and use_rs2 of the instruction now in EX.
- Entry PIPE_DEPTH+1 is the instruction that wrote the RF last cycle. It covers the RF write/ID read race.
- Producer match at entry k: valid & regwrite & rd≠0 & rd equals the source register & source is used.
- Load-use hazard: an ID source (id_valid) matches any entry k with memread and k ≤ LOAD_READY−2. With the defaults this is entry 1 only.
- `freeze` = mem_busy.
- `flush_ifid` = ex_redirect & !mem_busy.
- `stall` = hazard & !ex_redirect & !mem_busy.
- `bubble` = (hazard | ex_redirect) & !mem_busy.
- ex_redirect always wins over hazard; the stalled instruction is discarded anyway.
- Shift on each edge when !freeze: entry k+1 ← entry k for k = 1..PIPE_DEPTH. Entry 1 ← bubble ? invalid : ID fields (valid = id_valid).
- When freeze: all entries hold, and forwarding outputs stay consistent with the held state.
- Forwarding for each EX operand: select the lowest-index (youngest) matching entry k in 2..PIPE_DEPTH+1. Otherwise select 0.
- A matching load at k < LOAD_READY never selects its entry; sel = 0. The stall logic makes this unreachable.
- Entry 1 invalid forces both sels to 0.
- `stall_cnt` +1 on each cycle with stall=1.
- `flush_cnt` +1 on each cycle with flush_ifid=1.
- Both counters saturate at all-ones.

## Timing
- stall, bubble, flush_ifid and freeze are combinational from the ID inputs, ex_redirect, mem_busy and registered entries. They are valid in the same cycle.
- fwd_*_sel is combinational from registered entries only. There is no path from ID inputs.
- Load-use stall length with defaults is 1 cycle. In general it is LOAD_READY−1−k cycles for a producer at entry k.
- Counters and entries update on the rising edge.
- Reset (including mid-operation): all entries invalid. stall/bubble/flush_ifid/fwd sels evaluate to 0, freeze follows mem_busy. Counters = 0. Reset overrides mem_busy.

## Test plan
- Back-to-back ALU dependency (x5 ← add, next instr reads x5 as rs1) -> no stall; next cycle fwd_a_sel = 2; one cycle later a third reader of x5 gets fwd_a_sel = 3.
- Load then dependent add (lw x6; add x7,x6,x1) -> stall=1 and bubble=1 for exactly 1 cycle. Then fwd_a_sel = 3 for the add in EX. stall_cnt = 1.
- Producer in entry 4 (written to RF the cycle the consumer was in ID) -> consumer in EX gets sel = 4. Writes to x0 never forward (sel = 0).
- ex_redirect=1 together with a load-use hazard -> stall=0, bubble=1, flush_ifid=1. flush_cnt increments by 1.
- mem_busy=1 for 3 cycles during a load-use hazard -> freeze=1 with stall/bubble=0 and entries unchanged. After release, exactly the single stall cycle occurs.
- PIPE_DEPTH=4, LOAD_READY=4 with a load followed by a dependent add -> 2 stall cycles, then sel = 4. Reset asserted mid-stall -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// pipe_hazard_unit: load-use stall, redirect flush, memory freeze and EX
// operand forwarding control from a shadow of the post-ID pipeline.  Rev 1.0
// ============================================================================
module pipe_hazard_unit #(
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_READY = 3,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16,
  localparam int FW        = $clog2(PIPE_DEPTH + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              stall,
  output logic              bubble,
  output logic              flush_ifid,
  output logic              freeze,
  output logic [FW-1:0]     fwd_a_sel,
  output logic [FW-1:0]     fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Entry N is the instruction that wrote the RF last cycle (RF write/read race).
  localparam int N = PIPE_DEPTH + 1;

  logic [N:1]        r_valid;
  logic [N:1]        r_rw;
  logic [N:1]        r_mr;
  logic [REG_AW-1:0] r_rd [1:N];
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic              r_use1;
  logic              r_use2;
  logic              w_hazard;

  function automatic logic prod_match(input int k, input logic [REG_AW-1:0] rs,
                                      input logic use_rs);
    return r_valid[k] & r_rw[k] & (r_rd[k] != '0) & use_rs & (r_rd[k] == rs);
  endfunction

  // Only loads too young to forward even after one more cycle force a stall.
  always_comb begin
    w_hazard = 1'b0;
    for (int k = 1; k <= LOAD_READY - 2; k++) begin
      if (r_mr[k] && (prod_match(k, id_rs1, id_use_rs1) ||
                      prod_match(k, id_rs2, id_use_rs2)))
        w_hazard = 1'b1;
    end
    w_hazard = w_hazard & id_valid;
  end

  assign freeze     = mem_busy;
  assign flush_ifid = ex_redirect & ~mem_busy;
  assign stall      = w_hazard & ~ex_redirect & ~mem_busy;
  assign bubble     = (w_hazard | ex_redirect) & ~mem_busy;

  // Walk oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = N; k >= 2; k--) begin
      if (prod_match(k, r_rs1, r_use1))
        fwd_a_sel = (r_mr[k] && k < LOAD_READY) ? FW'(0) : FW'(k);
      if (prod_match(k, r_rs2, r_use2))
        fwd_b_sel = (r_mr[k] && k < LOAD_READY) ? FW'(0) : FW'(k);
    end
    if (!r_valid[1]) begin
      fwd_a_sel = '0;
      fwd_b_sel = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= '0;
      r_rw      <= '0;
      r_mr      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_use1    <= 1'b0;
      r_use2    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      for (int k = 1; k <= N; k++) r_rd[k] <= '0;
    end else begin
      if (!mem_busy) begin
        for (int k = N; k >= 2; k--) begin
          r_valid[k] <= r_valid[k-1];
          r_rw[k]    <= r_rw[k-1];
          r_mr[k]    <= r_mr[k-1];
          r_rd[k]    <= r_rd[k-1];
        end
        r_valid[1] <= id_valid & ~bubble;
        r_rw[1]    <= id_regwrite;
        r_mr[1]    <= id_memread;
        r_rd[1]    <= id_rd;
        r_rs1      <= id_rs1;
        r_rs2      <= id_rs2;
        r_use1     <= id_use_rs1;
        r_use2     <= id_use_rs2;
      end
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ifid && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
